spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
Parametrised successor to the team's SPI slave that fronts the single-port RAM. It deserialises a command frame of 2 command bits followed by DATA_W payload bits, and presents the frame to the RAM side with a one-cycle rx_valid pulse. On a read-data command it waits for the RAM response and serialises DATA_W bits back on MISO. Over the previous generation it adds:
- generic widths
- an explicit read sequencing check
- a tx response timeout
- frame-abort detection

Parameters:
DATA_W, 8, payload width in bits; rx_data width is DATA_W+2, tx_data width is DATA_W.
TX_TIMEOUT, 16, maximum number of clk cycles WAIT_TX waits for tx_valid before aborting (must be ≥1).

Ports:
clk  input  1  system clock; SPI bits sampled/driven on rising edge.
rst  input  1  reset, synchronous, active-high.
SS_n  input  1  slave select, active low; frame lasts while low.
MOSI  input  1  serial data in, MSB first.
MISO  output  1  serial data out, MSB first; 0 when not shifting.
rx_data  output  DATA_W+2  captured frame {cmd[1:0], payload}.
rx_valid  output  1  one-cycle pulse, rx_data valid.
tx_data  input  DATA_W  read data from RAM.
tx_valid  input  1  tx_data valid, sampled only in WAIT_TX.
busy  output  1  high in any state other than IDLE.
err  output  1  one-cycle error pulse.
err_code  output  2  cause of the last err (01 abort, 10 read-sequence, 11 timeout); holds until next err.

Behaviour:
- Reset (rst high at a rising edge, priority over everything, legal mid-frame) sets:
  - state IDLE;
  - MISO, rx_valid, err, busy all 0;
  - rx_data 0, err_code 00;
  - rd_addr_seen 0, counters 0.
- States: IDLE, RX, DONE, WAIT_TX, SHIFT_TX.
- IDLE:
  - SS_n low sampled → RX.
  - The MOSI bit sampled in that same cycle is bit 1 of the frame (cmd[1]); the shift register is loaded with it and bit_cnt=1.
- RX:
  - Each cycle shift MOSI into the LSB and increment bit_cnt.
  - When bit_cnt reaches DATA_W+2, the next cycle drives rx_data = shift register and rx_valid=1 for exactly one cycle.
  - rx_valid therefore rises DATA_W+2 cycles after the cycle SS_n is first sampled low.
- Command decode, at frame completion:
  - 00 write-address, 01 write-data → DONE.
  - 10 read-address → set rd_addr_seen, go to DONE.
  - 11 read-data with rd_addr_seen=1 → clear rd_addr_seen, go to WAIT_TX.
  - 11 read-data with rd_addr_seen=0 → rx_valid still pulses; err=1, err_code=10; go to DONE (no shift-out).
- DONE: ignore MOSI, MISO=0, stay until SS_n high.
- WAIT_TX:
  - tx_valid high → latch tx_data into tx_shift, go to SHIFT_TX.
  - MISO=tx_data[DATA_W-1] from the next cycle.
  - If TX_TIMEOUT cycles elapse without tx_valid → err=1, err_code=11, go to DONE.
- SHIFT_TX:
  - Drive one bit per cycle, MSB first, for DATA_W cycles, then DONE with MISO=0.
  - tx_valid is ignored outside WAIT_TX.
- SS_n high in any non-IDLE state → IDLE next cycle, MISO=0.
  - If the state was RX with bit_cnt < DATA_W+2, or was WAIT_TX or SHIFT_TX: err=1, err_code=01, no rx_valid.
  - SS_n high in the same cycle the last RX bit is sampled counts as complete: rx_valid pulses, no error.
- rd_addr_seen persists across frames; it is cleared only by reset or by a successful read-data command.
- A second read-address overwrites, with no error.
- busy is combinational from state.

Test Plan:
1. DATA_W=8; SS_n low, MOSI 00_1010_0101 → rx_data=10'h0A5, rx_valid single pulse 10 cycles after SS_n first low; err=0; MISO=0 throughout.
2. Read-address frame 10_0000_0011 then read-data frame 11_xxxx_xxxx, tx_valid with tx_data=8'hC3 after 3 cycles → MISO shows 1,1,0,0,0,0,1,1 on consecutive cycles; err=0.
3. Read-data frame with no preceding read-address → rx_valid pulses with rx_data[9:8]=11, err pulse with err_code=10, MISO stays 0.
4. SS_n raised after 6 of 10 bits → no rx_valid, err pulse with err_code=01, busy=0 next cycle.
5. Valid read sequence, tx_valid never asserted → err pulse exactly TX_TIMEOUT=16 cycles after entering WAIT_TX, err_code=11, MISO=0.
6. rst asserted mid-SHIFT_TX (bit 4 of 8) → next cycle MISO=0, busy=0; a following read-data frame flags err_code=10 because rd_addr_seen was cleared.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM: deserialises {cmd[1:0], payload} frames,
// serialises read data back on MISO, and flags aborted frames, bad read sequences and timeouts.
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_MAX = (FRAME_W > TX_TIMEOUT) ? FRAME_W : TX_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TX_TIMEOUT - 1);

    localparam logic [1:0] ERR_ABORT = 2'b01;
    localparam logic [1:0] ERR_RDSEQ = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_DONE,
        S_WAIT_TX,
        S_SHIFT_TX
    } state_t;

    state_t             state_q, state_d, decode_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               miso_q, miso_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               rd_seen_q, rd_seen_d;
    logic [1:0]         cmd;

    assign cmd = rx_shift_q[FRAME_W-1 -: 2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        miso_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        rd_seen_d   = rd_seen_q;
        decode_next = S_DONE;

        case (state_q)
            S_IDLE: begin
                if (!SS_n) begin
                    state_d    = S_RX;
                    rx_shift_d = {{(FRAME_W-1){1'b0}}, MOSI};
                    cnt_d      = CNT_W'(1);
                end
            end

            S_RX: begin
                if (cnt_q == FRAME_CNT) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    if (cmd == 2'b10) begin
                        rd_seen_d = 1'b1;
                    end else if (cmd == 2'b11) begin
                        if (rd_seen_q) begin
                            rd_seen_d   = 1'b0;
                            decode_next = S_WAIT_TX;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_RDSEQ;
                        end
                    end
                    state_d = SS_n ? S_IDLE : decode_next;
                end else if (SS_n && cnt_q != LAST_CNT) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                end else begin
                    // The final bit still counts if SS_n rises on the cycle it is sampled.
                    rx_shift_d = {rx_shift_q[FRAME_W-2:0], MOSI};
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_TX: begin
                if (SS_n) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                end else if (tx_valid) begin
                    state_d    = S_SHIFT_TX;
                    miso_d     = tx_data[DATA_W-1];
                    tx_shift_d = tx_data << 1;
                    cnt_d      = CNT_W'(1);
                end else if (cnt_q == TMO_LAST) begin
                    state_d    = S_DONE;
                    cnt_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SHIFT_TX: begin
                if (SS_n) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                end else if (cnt_q == DATA_CNT) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    miso_d     = tx_shift_q[DATA_W-1];
                    tx_shift_d = tx_shift_q << 1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                if (SS_n) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param (DATA_W=8, TX_TIMEOUT=16): inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_spi_slave_param;

    localparam int DATA_W     = 8;
    localparam int TX_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    int   checks   = 0;
    int   failures = 0;
    int   rxv_acc;
    int   err_acc;
    logic miso_acc;
    logic [7:0] obs;

    spi_slave_param #(.DATA_W(DATA_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        miso_acc = miso_acc | MISO;
        rxv_acc  = rxv_acc + int'(rx_valid);
        err_acc  = err_acc + int'(err);
    endtask

    task automatic clr_acc();
        miso_acc = 1'b0;
        rxv_acc  = 0;
        err_acc  = 0;
    endtask

    // Sends the n most significant bits of f, MSB first, with SS_n held low.
    task automatic send_bits(input logic [9:0] f, input int n);
        for (int i = 9; i > 9 - n; i--) begin
            SS_n = 1'b0;
            MOSI = f[i];
            tick();
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
        clr_acc();
        tick(); tick();
        chk("rst_miso", MISO, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_err_code", err_code, 0);
        rst = 1'b0;
        tick();

        // Write-address frame: rx_valid exactly 10 cycles after SS_n first sampled low.
        clr_acc();
        send_bits(10'h0A5, 10);
        chk("t1_no_early_valid", rxv_acc, 0);
        chk("t1_busy_rx", busy, 1);
        SS_n = 1'b0; MOSI = 1'b0;
        tick();
        chk("t1_rx_valid", rx_valid, 1);
        chk("t1_rx_data", rx_data, 10'h0A5);
        chk("t1_err", err, 0);
        tick();
        chk("t1_single_pulse", rx_valid, 0);
        chk("t1_busy_done", busy, 1);
        end_frame();
        chk("t1_busy_idle", busy, 0);
        chk("t1_miso_quiet", miso_acc, 0);
        chk("t1_pulse_count", rxv_acc, 1);
        chk("t1_no_err", err_acc, 0);

        // Read-address then read-data; RAM answers 8'hC3 after a short delay.
        clr_acc();
        send_bits(10'h203, 10);
        tick();
        chk("t2_ra_data", rx_data, 10'h203);
        end_frame();
        send_bits(10'h300, 10);
        tick();
        chk("t2_rd_valid", rx_valid, 1);
        chk("t2_rd_data", rx_data, 10'h300);
        chk("t2_busy_wait", busy, 1);
        tick(); tick();
        chk("t2_miso_wait", MISO, 0);
        tx_valid = 1'b1; tx_data = 8'hC3;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        obs = '0;
        for (int k = 0; k < 8; k++) begin
            obs = {obs[6:0], MISO};
            tick();
        end
        chk("t2_miso_bits", obs, 8'hC3);
        chk("t2_miso_after", MISO, 0);
        chk("t2_busy_done", busy, 1);
        chk("t2_no_err", err_acc, 0);
        end_frame();

        // Read-data without a preceding read-address.
        clr_acc();
        send_bits(10'h3FF, 10);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        chk("t3_rx_valid", rx_valid, 1);
        chk("t3_rx_data", rx_data, 10'h3FF);
        chk("t3_err", err, 1);
        chk("t3_err_code", err_code, 2'b10);
        tick(); tick();
        chk("t3_err_pulse", err, 0);
        chk("t3_miso_quiet", miso_acc, 0);
        tx_valid = 1'b0; tx_data = 8'h00;
        end_frame();
        chk("t3_err_count", err_acc, 1);

        // Abort after 6 of 10 bits.
        clr_acc();
        send_bits(10'h0FF, 6);
        end_frame();
        chk("t4_err", err, 1);
        chk("t4_err_code", err_code, 2'b01);
        chk("t4_busy", busy, 0);
        tick();
        chk("t4_err_pulse", err, 0);
        chk("t4_no_valid", rxv_acc, 0);

        // SS_n rises on the cycle the last bit is sampled: still a complete frame.
        clr_acc();
        send_bits(10'h155, 9);
        SS_n = 1'b1; MOSI = 1'b1;
        tick();
        chk("t5_last_no_err", err, 0);
        MOSI = 1'b0;
        tick();
        chk("t5_last_valid", rx_valid, 1);
        chk("t5_last_data", rx_data, 10'h155);
        chk("t5_last_busy", busy, 0);
        chk("t5_last_err_count", err_acc, 0);

        // Valid read sequence with no RAM response: timeout after 16 cycles.
        send_bits(10'h203, 10);
        tick();
        end_frame();
        send_bits(10'h300, 10);
        tick();
        clr_acc();
        repeat (TX_TIMEOUT - 1) tick();
        chk("t6_no_early_tmo", err_acc, 0);
        tick();
        chk("t6_tmo_err", err, 1);
        chk("t6_tmo_code", err_code, 2'b11);
        chk("t6_tmo_miso", MISO, 0);
        chk("t6_tmo_busy", busy, 1);
        end_frame();
        chk("t6_busy_idle", busy, 0);

        // Reset in the middle of shift-out clears the read-address flag.
        send_bits(10'h203, 10);
        tick();
        end_frame();
        send_bits(10'h300, 10);
        tick();
        tick();
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        tick(); tick(); tick();
        chk("t7_miso_mid", MISO, 1);
        rst = 1'b1; SS_n = 1'b1;
        tick();
        chk("t7_rst_miso", MISO, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_err_code", err_code, 0);
        rst = 1'b0;
        tick();
        send_bits(10'h300, 10);
        tick();
        chk("t7_rd_valid", rx_valid, 1);
        chk("t7_rd_err", err, 1);
        chk("t7_rd_err_code", err_code, 2'b10);
        end_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
